// File: rtl/ipv4_arp_lut_pkg.sv
// ipv4_arp_lut_pkg: shared widths and one-hot FSM encoding for the ARP resolver
package ipv4_arp_lut_pkg;
   localparam int MAC_WIDTH  = 48;
   localparam int IPV4_WIDTH = 32;
   localparam int ENTRIES    = 32;
   localparam int IDX_WIDTH  = 5;
   typedef enum logic [3:0] {
      IDLE    = 4'd1,
      MATCH   = 4'd2,
      RESOLVE = 4'd4,
      DONE    = 4'd8
   } state_t;
endpackage

// File: rtl/ipv4_arp_lut_prio_enc.sv
// arp_lut_prio_enc: hit flag and lowest set index of a match vector
module arp_lut_prio_enc #(
   parameter int N     = 32,
   parameter int IDX_W = 5
) (
   input  logic [N-1:0]     i_vec,
   output logic             o_hit,
   output logic [IDX_W-1:0] o_idx
);
   assign o_hit = |i_vec;
   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--)
         if (i_vec[i]) o_idx = IDX_W'(i);
   end
endmodule

// File: rtl/ipv4_arp_lut.sv
// ipv4_arp_lut: resolves a FIB next hop to a MAC via a CPU-managed table, holding the result until consumed
module ipv4_arp_lut #(
   parameter int MAC_WIDTH = ipv4_arp_lut_pkg::MAC_WIDTH,
   parameter int ENTRIES   = ipv4_arp_lut_pkg::ENTRIES,
   parameter int IDX_WIDTH = ipv4_arp_lut_pkg::IDX_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          i_ipv4_fib_lut_nh,
   input  logic                 i_ipv4_fib_lut_nh_found,
   input  logic                 i_ipv4_fib_lut_valid,
   input  logic                 i_rd_from_magic,
   input  logic                 i_wr_en,
   input  logic [IDX_WIDTH-1:0] i_wr_addr,
   input  logic [31:0]          i_wr_ip,
   input  logic [MAC_WIDTH-1:0] i_wr_mac,
   input  logic                 i_wr_entry_valid,
   input  logic [IDX_WIDTH-1:0] i_rd_addr,
   output logic [31:0]          o_rd_ip,
   output logic [MAC_WIDTH-1:0] o_rd_mac,
   output logic                 o_rd_entry_valid,
   output logic                 o_ipv4_arp_lut_ipv4_eth_addr_found,
   output logic [MAC_WIDTH-1:0] o_ipv4_arp_lut_ipv4_eth_addr,
   output logic                 o_ipv4_arp_lut_valid
);
   import ipv4_arp_lut_pkg::*;

   logic [IPV4_WIDTH-1:0] r_ip [ENTRIES];
   logic [MAC_WIDTH-1:0]  r_mac [ENTRIES];
   logic [ENTRIES-1:0]    r_ev;
   logic [IPV4_WIDTH-1:0] r_nh;
   logic [ENTRIES-1:0]    r_match;
   state_t                r_state, w_next;
   logic [ENTRIES-1:0]    w_cmp;
   logic                  w_hit;
   logic [IDX_WIDTH-1:0]  w_idx;

   for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
      assign w_cmp[g] = r_ev[g] & (r_ip[g] == r_nh);
   end

   arp_lut_prio_enc #(.N(ENTRIES), .IDX_W(IDX_WIDTH)) u_prio (
      .i_vec (r_match),
      .o_hit (w_hit),
      .o_idx (w_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_ip[i]  <= '0;
            r_mac[i] <= '0;
         end
         r_ev             <= '0;
         o_rd_ip          <= '0;
         o_rd_mac         <= '0;
         o_rd_entry_valid <= 1'b0;
      end else begin
         if (i_wr_en) begin
            r_ip[i_wr_addr]  <= i_wr_ip;
            r_mac[i_wr_addr] <= i_wr_mac;
            r_ev[i_wr_addr]  <= i_wr_entry_valid;
         end
         o_rd_ip          <= r_ip[i_rd_addr];
         o_rd_mac         <= r_mac[i_rd_addr];
         o_rd_entry_valid <= r_ev[i_rd_addr];
      end
   end

   always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_ipv4_fib_lut_valid) w_next = i_ipv4_fib_lut_nh_found ? MATCH : RESOLVE;
         MATCH:   w_next = RESOLVE;
         RESOLVE: w_next = DONE;
         DONE:    if (i_rd_from_magic) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // A skipped search reaches RESOLVE with the match vector still cleared from IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_nh                               <= '0;
         r_match                            <= '0;
         o_ipv4_arp_lut_valid               <= 1'b0;
         o_ipv4_arp_lut_ipv4_eth_addr_found <= 1'b0;
         o_ipv4_arp_lut_ipv4_eth_addr       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_match <= '0;
               if (i_ipv4_fib_lut_valid) r_nh <= i_ipv4_fib_lut_nh;
            end
            MATCH: r_match <= w_cmp;
            RESOLVE: begin
               o_ipv4_arp_lut_valid               <= 1'b1;
               o_ipv4_arp_lut_ipv4_eth_addr_found <= w_hit;
               o_ipv4_arp_lut_ipv4_eth_addr       <= w_hit ? r_mac[w_idx] : '0;
            end
            DONE:
               if (i_rd_from_magic) begin
                  o_ipv4_arp_lut_valid               <= 1'b0;
                  o_ipv4_arp_lut_ipv4_eth_addr_found <= 1'b0;
                  o_ipv4_arp_lut_ipv4_eth_addr       <= '0;
               end
            default: r_match <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_ipv4_arp_lut.sv
// tb_ipv4_arp_lut: directed and randomized lookups checked against a table-scan reference model
module tb_ipv4_arp_lut;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] nh;
   logic        nh_found, fib_valid, rd_magic, wr_en, wr_ev;
   logic [4:0]  wr_addr, rd_addr;
   logic [31:0] wr_ip, rd_ip;
   logic [47:0] wr_mac, rd_mac, eth_addr;
   logic        rd_ev, found, valid;

   ipv4_arp_lut dut (
      .clk                                (clk),
      .reset                              (reset),
      .i_ipv4_fib_lut_nh                  (nh),
      .i_ipv4_fib_lut_nh_found            (nh_found),
      .i_ipv4_fib_lut_valid               (fib_valid),
      .i_rd_from_magic                    (rd_magic),
      .i_wr_en                            (wr_en),
      .i_wr_addr                          (wr_addr),
      .i_wr_ip                            (wr_ip),
      .i_wr_mac                           (wr_mac),
      .i_wr_entry_valid                   (wr_ev),
      .i_rd_addr                          (rd_addr),
      .o_rd_ip                            (rd_ip),
      .o_rd_mac                           (rd_mac),
      .o_rd_entry_valid                   (rd_ev),
      .o_ipv4_arp_lut_ipv4_eth_addr_found (found),
      .o_ipv4_arp_lut_ipv4_eth_addr       (eth_addr),
      .o_ipv4_arp_lut_valid               (valid)
   );

   always #5 clk = ~clk;

   logic [31:0] m_ip [32];
   logic [47:0] m_mac [32];
   logic        m_ev [32];
   int          n_chk = 0, n_pass = 0, cyc = 0, t0 = 0;
   logic [31:0] pool [4];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic model_clear;
      for (int i = 0; i < 32; i++) begin
         m_ip[i] = '0; m_mac[i] = '0; m_ev[i] = 1'b0;
      end
   endtask

   task automatic model_lookup(input logic [31:0] a, input logic f, output logic ef, output logic [47:0] ea);
      ef = 1'b0; ea = '0;
      if (f)
         for (int i = 0; i < 32; i++)
            if (!ef && m_ev[i] && m_ip[i] == a) begin
               ef = 1'b1; ea = m_mac[i];
            end
   endtask

   task automatic wr(input int idx, input logic [31:0] ip, input logic [47:0] mac, input logic ev);
      wr_en = 1'b1; wr_addr = 5'(idx); wr_ip = ip; wr_mac = mac; wr_ev = ev;
      tick;
      wr_en = 1'b0;
      m_ip[idx] = ip; m_mac[idx] = mac; m_ev[idx] = ev;
   endtask

   task automatic launch(input logic [31:0] a, input logic f);
      nh = a; nh_found = f; fib_valid = 1'b1; t0 = cyc;
      tick;
   endtask

   task automatic wait_res(input string tag, input logic ef, input logic [47:0] ea, input int lat);
      int n = 0;
      while (!valid && n < 20) begin
         tick;
         n++;
      end
      chk({tag, "_latency"}, 64'(cyc - t0), 64'(lat));
      chk({tag, "_found"}, 64'(found), 64'(ef));
      chk({tag, "_addr"}, 64'(eth_addr), 64'(ea));
   endtask

   task automatic consume(input string tag, input logic [47:0] ea);
      tick;
      chk({tag, "_held"}, 64'(valid), 64'd1);
      rd_magic = 1'b1;
      chk({tag, "_addr_at_rd"}, 64'(eth_addr), 64'(ea));
      tick;
      rd_magic = 1'b0; fib_valid = 1'b0;
      chk({tag, "_valid_clr"}, 64'(valid), 64'd0);
      chk({tag, "_found_clr"}, 64'(found), 64'd0);
      chk({tag, "_addr_clr"}, 64'(eth_addr), 64'd0);
   endtask

   task automatic lookup(input string tag, input logic [31:0] a, input logic f);
      logic ef;
      logic [47:0] ea;
      model_lookup(a, f, ef, ea);
      launch(a, f);
      wait_res(tag, ef, ea, f ? 3 : 2);
      consume(tag, ea);
   endtask

   initial begin
      logic        ef;
      logic [47:0] ea;
      reset = 1'b1; nh = '0; nh_found = 1'b0; fib_valid = 1'b0; rd_magic = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_ip = '0; wr_mac = '0; wr_ev = 1'b0; rd_addr = 5'd3;
      model_clear();
      tick; tick;
      reset = 1'b0;
      tick;
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_found", 64'(found), 64'd0);
      chk("rst_addr", 64'(eth_addr), 64'd0);
      chk("rst_rd_ip", 64'(rd_ip), 64'd0);

      wr(3, 32'h0A000001, 48'h001122334455, 1'b1);
      lookup("t1_hit", 32'h0A000001, 1'b1);
      chk("t1_const", 64'(m_mac[3]), 64'h001122334455);

      lookup("t2_miss", 32'h0A000009, 1'b1);
      wr(4, 32'h0A000009, 48'hDEADBEEF0001, 1'b0);
      lookup("t2_invalid_entry", 32'h0A000009, 1'b1);

      lookup("t3_fib_miss", 32'h0A000001, 1'b0);

      wr(1, 32'hC0A80101, 48'hAAAAAAAAAAAA, 1'b1);
      wr(7, 32'hC0A80101, 48'hBBBBBBBBBBBB, 1'b1);
      model_lookup(32'hC0A80101, 1'b1, ef, ea);
      launch(32'hC0A80101, 1'b1);
      wait_res("t4_dup", ef, ea, 3);
      wr(1, 32'hC0A80101, 48'hCCCCCCCCCCCC, 1'b1);
      chk("t4_done_stable", 64'(eth_addr), 64'(ea));
      consume("t4_dup", ea);
      lookup("t4_after_rewrite", 32'hC0A80101, 1'b1);

      launch(32'h0A010101, 1'b1);
      wr_en = 1'b1; wr_addr = 5'd2; wr_ip = 32'h0A010101; wr_mac = 48'h020000000002; wr_ev = 1'b1;
      tick;
      wr_en = 1'b0;
      wait_res("t5_wr_in_match", 1'b0, 48'h0, 3);
      consume("t5_wr_in_match", 48'h0);
      m_ip[2] = 32'h0A010101; m_mac[2] = 48'h020000000002; m_ev[2] = 1'b1;
      rd_addr = 5'd2;
      tick;
      chk("t5_rb_ip", 64'(rd_ip), 64'(m_ip[2]));
      chk("t5_rb_mac", 64'(rd_mac), 64'(m_mac[2]));
      chk("t5_rb_ev", 64'(rd_ev), 64'(m_ev[2]));
      lookup("t5_next_hits", 32'h0A010101, 1'b1);
      rd_addr = 5'd5;
      wr_en = 1'b1; wr_addr = 5'd5; wr_ip = 32'h05050505; wr_mac = 48'h050505050505; wr_ev = 1'b1;
      tick;
      wr_en = 1'b0;
      chk("t5_rb_same_cycle_old", 64'(rd_ip), 64'(m_ip[5]));
      m_ip[5] = 32'h05050505; m_mac[5] = 48'h050505050505; m_ev[5] = 1'b1;
      tick;
      chk("t5_rb_new", 64'(rd_ip), 64'(m_ip[5]));

      launch(32'h0A000001, 1'b1);
      reset = 1'b1; fib_valid = 1'b0;
      tick;
      reset = 1'b0;
      model_clear();
      chk("t6_rst_valid", 64'(valid), 64'd0);
      chk("t6_rst_rb", 64'(rd_ip), 64'd0);
      tick;
      chk("t6_no_result", 64'(valid), 64'd0);
      lookup("t6_empty_miss", 32'h0A000001, 1'b1);

      for (int i = 0; i < 4; i++) pool[i] = $urandom;
      for (int i = 0; i < 32; i++)
         if ($urandom_range(0, 1) == 1)
            wr(i, pool[$urandom_range(0, 3)], {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
      for (int k = 0; k < 24; k++)
         lookup("rand", ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 3)],
                1'($urandom_range(0, 4) != 0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
